counter_cmd_driver: RTL

//  Initiator side of the 8-bit up/down counter control interface (d/clear/load/up_down in, qd out).

---
 rtl/counter_cmd_driver_if.sv | 24 ++
 rtl/counter_cmd_driver.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/counter_cmd_driver_if.sv
// Command port of counter_cmd_driver: valid/ready handshake carrying a 2-bit opcode
// and a WIDTH-bit argument.
interface counter_cmd_driver_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_driver.sv
// Initiator for the 8-bit up/down counter: executes CLEAR/LOAD/UP/DOWN commands, mirrors the count in a
// shadow register and (when CNT_DRV_CHECK_EN is defined) flags cycles where ctr_qd disagrees with it.
module counter_cmd_driver #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    counter_cmd_driver_if.slave cmd,
    output logic              ctr_clear,
    output logic              ctr_load,
    output logic              ctr_up_down,
    output logic [WIDTH-1:0]  ctr_d,
    input  logic [WIDTH-1:0]  ctr_qd,
    output logic              busy,
    output logic              wrap_pulse,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_LD,
        ST_CNT
    } state_e;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ud_q, ud_d;
    logic [WIDTH-1:0] ld_val_q, ld_val_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             wrap_q, wrap_d;
    logic             armed_q, armed_d;
    logic             ready_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            ud_q     <= 1'b1;
            ld_val_q <= '0;
            shadow_q <= '0;
            wrap_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            ud_q     <= ud_d;
            ld_val_q <= ld_val_d;
            shadow_q <= shadow_d;
            wrap_q   <= wrap_d;
            armed_q  <= armed_d;
        end
    end

    // Direction is latched at accept, so the accept cycle itself still counts in the previous direction.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        ud_d      = ud_q;
        ld_val_d  = ld_val_q;
        ready_c   = 1'b0;
        ctr_clear = 1'b0;
        ctr_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (cmd.cmd_valid) begin
                    case (op_e'(cmd.cmd_op))
                        OP_CLEAR: state_d = ST_CLR;
                        OP_LOAD: begin
                            state_d  = ST_LD;
                            ld_val_d = cmd.cmd_arg;
                        end
                        default: begin
                            state_d = ST_CNT;
                            ud_d    = ~cmd.cmd_op[0];
                            rem_d   = (cmd.cmd_arg == '0) ? WIDTH'(1) : cmd.cmd_arg;
                        end
                    endcase
                end
            end
            ST_CLR: begin
                ctr_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_LD: begin
                ctr_load = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_CNT: begin
                if (rem_q <= WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_q - WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow follows the pins exactly as the counter sees them, including free counting while idle.
    always_comb begin
        shadow_d = shadow_q;
        wrap_d   = 1'b0;
        armed_d  = armed_q | ctr_clear | ctr_load;
        if (ctr_clear) begin
            shadow_d = '0;
        end else if (ctr_load) begin
            shadow_d = ld_val_q;
        end else if (ud_q) begin
            shadow_d = shadow_q + WIDTH'(1);
            wrap_d   = &shadow_q;
        end else begin
            shadow_d = shadow_q - WIDTH'(1);
            wrap_d   = ~|shadow_q;
        end
    end

    assign cmd.cmd_ready = ready_c;
    assign busy          = ~ready_c;
    assign ctr_up_down   = ud_q;
    assign ctr_d         = ld_val_q;
    assign wrap_pulse    = wrap_q;

`ifdef CNT_DRV_CHECK_EN
    logic             mismatch_q;
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else if (armed_q && (ctr_qd != shadow_q)) begin
            mismatch_q <= 1'b1;
            if (err_q != '1) begin
                err_q <= err_q + ERR_W'(1);
            end
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{ctr_qd, armed_q};
    assign mismatch   = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule
